// File: rtl/dm_access_arbiter_if.sv
// dm_access_arbiter_if: CPU, debug and data-memory buses around the DM access arbiter.
interface dm_access_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req_i, cpu_we_i, cpu_ack_o, cpu_stall_o;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i, cpu_rdata_o;
  logic              dbg_req_i, dbg_we_i, dbg_ack_o;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i, dbg_rdata_o;
  logic              mem_en_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_ack_o, cpu_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_rdata_o, dbg_ack_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_ack_o, cpu_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_rdata_o, dbg_ack_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares one single-port data memory between the CPU MEM stage and a debug port.
module dm_access_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int CPU_PRIO   = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dm_access_arbiter_if.slave bus,
  output logic               busy_o,
  output logic               owner_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state;
  logic [3:0]        lat_cnt, starve_cnt;
  logic              last_owner, l_we, mem_en, cpu_ack, dbg_ack, win_dbg;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata, cpu_rdata, dbg_rdata;
  always_comb begin
    win_dbg = !bus.cpu_req_i ? bus.dbg_req_i :
              !bus.dbg_req_i ? 1'b0 :
              (CPU_PRIO != 0) ? (starve_cnt >= 4'(STARVE_LIM)) : !last_owner;
  end
  assign bus.mem_en_o    = mem_en;
  assign bus.mem_we_o    = mem_en & l_we;
  assign bus.mem_addr_o  = l_addr;
  assign bus.mem_wdata_o = l_wdata;
  assign bus.cpu_ack_o   = cpu_ack;
  assign bus.dbg_ack_o   = dbg_ack;
  assign bus.cpu_rdata_o = cpu_rdata;
  assign bus.dbg_rdata_o = dbg_rdata;
  assign bus.cpu_stall_o = bus.cpu_req_i & ~cpu_ack;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      last_owner <= 1'b1;
      owner_o    <= 1'b0;
      busy_o     <= 1'b0;
      mem_en     <= 1'b0;
      l_we       <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        IDLE: if (bus.cpu_req_i || bus.dbg_req_i) begin
          state      <= ACCESS;
          busy_o     <= 1'b1;
          mem_en     <= 1'b1;
          lat_cnt    <= '0;
          owner_o    <= win_dbg;
          last_owner <= win_dbg;
          l_we       <= win_dbg ? bus.dbg_we_i : bus.cpu_we_i;
          l_addr     <= win_dbg ? bus.dbg_addr_i : bus.cpu_addr_i;
          l_wdata    <= win_dbg ? bus.dbg_wdata_i : bus.cpu_wdata_i;
          // debug losing while pending counts toward its forced win
          starve_cnt <= win_dbg ? 4'd0 :
                        (bus.dbg_req_i && starve_cnt != 4'hf) ? starve_cnt + 4'd1 : starve_cnt;
        end
        ACCESS: if (lat_cnt == 4'(MEM_LAT - 1)) begin
          state   <= RESP;
          mem_en  <= 1'b0;
          cpu_ack <= !owner_o;
          dbg_ack <= owner_o;
          if (!l_we && owner_o) dbg_rdata <= bus.mem_rdata_i;
          if (!l_we && !owner_o) cpu_rdata <= bus.mem_rdata_i;
        end else begin
          lat_cnt <= lat_cnt + 4'd1;
        end
        RESP: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter: directed bench running a priority and a round-robin arbiter side by side against a cycle-timeline model.
module tb_dm_access_arbiter;
  localparam int L = 2, LIM = 4;
  logic clk = 1'b0, rst = 1'b1, preload = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic [1:0] cack, dack, men, busy, own;
  logic [31:0] crd [2];
  logic [31:0] drd [2];
  logic [31:0] maddr [2];
  bit checking = 1'b0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (i == 16) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  for (genvar m = 0; m < 2; m++) begin : g
    dm_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic busy_o, owner_o;
    logic [31:0] dm [256];
    dm_access_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .CPU_PRIO(m == 0 ? 1 : 0),
                        .STARVE_LIM(LIM)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy_o), .owner_o(owner_o));
    assign bus.cpu_req_i   = cpu_req;
    assign bus.cpu_we_i    = cpu_we;
    assign bus.cpu_addr_i  = cpu_addr;
    assign bus.cpu_wdata_i = cpu_wdata;
    assign bus.dbg_req_i   = dbg_req;
    assign bus.dbg_we_i    = dbg_we;
    assign bus.dbg_addr_i  = dbg_addr;
    assign bus.dbg_wdata_i = dbg_wdata;
    assign bus.mem_rdata_i = dm[bus.mem_addr_o[7:0]];
    assign cack[m]  = bus.cpu_ack_o;
    assign dack[m]  = bus.dbg_ack_o;
    assign men[m]   = bus.mem_en_o;
    assign busy[m]  = busy_o;
    assign own[m]   = owner_o;
    assign crd[m]   = bus.cpu_rdata_o;
    assign drd[m]   = bus.dbg_rdata_o;
    assign maddr[m] = bus.mem_addr_o;

    always @(posedge clk)
      if (preload) for (int i = 0; i < 256; i++) dm[i] <= init_word(i);
      else if (bus.mem_en_o && bus.mem_we_o) dm[bus.mem_addr_o[7:0]] <= bus.mem_wdata_o;

    // Model: each grant at cycle gc means enable in gc+1..gc+L, ack at gc+L+1, next arbitration at gc+L+2.
    int cyc = 0, next_arb = 0, gc = -100, starve = 0;
    bit gown = 1'b0, gwe = 1'b0, last = 1'b1, wd;
    logic [31:0] ga = '0, gw = '0, ecr = '0, edr = '0;
    logic [31:0] mm [256];
    initial forever begin
      @(posedge clk);
      if (rst) begin
        if (preload) for (int i = 0; i < 256; i++) mm[i] = init_word(i);
        next_arb = cyc + 1; gc = -100; starve = 0; last = 1'b1;
        gown = 1'b0; gwe = 1'b0; ga = '0; gw = '0; ecr = '0; edr = '0;
      end else if (cyc >= next_arb && (cpu_req || dbg_req)) begin
        if (cpu_req && dbg_req) wd = (m == 0) ? (starve >= LIM) : (last == 1'b0);
        else wd = dbg_req;
        if (wd) starve = 0;
        else if (dbg_req) starve = (starve < 15) ? starve + 1 : 15;
        gown = wd; last = wd; gc = cyc; next_arb = cyc + L + 2;
        gwe = wd ? dbg_we : cpu_we;
        ga = wd ? dbg_addr : cpu_addr;
        gw = wd ? dbg_wdata : cpu_wdata;
        if (gwe) mm[ga[7:0]] = gw;
      end else if (cyc == gc + L && !gwe) begin
        if (gown) edr = mm[ga[7:0]];
        else ecr = mm[ga[7:0]];
      end
      cyc++;
    end

    initial forever begin
      bit en, ack, bz;
      logic [6:0] act, exp;
      @(negedge clk);
      if (checking) begin
        en  = (cyc > gc) && (cyc <= gc + L);
        ack = (cyc == gc + L + 1);
        bz  = (cyc > gc) && (cyc <= gc + L + 1);
        exp = {en, en & gwe, ack & !gown, ack & gown, bz, gown, cpu_req & !(ack & !gown)};
        act = {bus.mem_en_o, bus.mem_we_o, bus.cpu_ack_o, bus.dbg_ack_o, busy_o, owner_o, bus.cpu_stall_o};
        check($sformatf("m%0d en/we/cack/dack/busy/own/stall @%0d", m, cyc), 32'(act), 32'(exp));
        check($sformatf("m%0d mem_addr @%0d", m, cyc), bus.mem_addr_o, ga);
        check($sformatf("m%0d mem_wdata @%0d", m, cyc), bus.mem_wdata_o, gw);
        check($sformatf("m%0d cpu_rdata @%0d", m, cyc), bus.cpu_rdata_o, ecr);
        check($sformatf("m%0d dbg_rdata @%0d", m, cyc), bus.dbg_rdata_o, edr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit dbg, output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dbg ? dack[0] : cack[0]) begin
        lat = k;
        return;
      end
    end
    total++; bad++;
    $display("FAIL ack_timeout: no %s ack within 20 cycles", dbg ? "dbg" : "cpu");
  endtask

  task automatic op(input bit dbg, input bit we, input logic [31:0] a, input logic [31:0] d, output int lat);
    if (dbg) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
    else begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    wait_ack(dbg, lat);
    tick();
    if (dbg) dbg_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy == 2'b00) begin
        tick();
        return;
      end
    end
    total++; bad++;
    $display("FAIL idle_timeout: busy=%b want 00", busy);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n0, n1;
    logic [9:0] s0, s1;
    int ta[$];
    repeat (3) tick();
    checking = 1'b1;
    rst = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    check("reset mem_en", 32'(men), 0);
    check("reset busy", 32'(busy), 0);
    check("reset owner", 32'(own), 0);
    check("reset cpu_rdata", crd[0], 0);
    tick();
    // single CPU read
    op(1'b0, 1'b0, 32'h10, 32'h0, lat);
    check("cpu read latency", 32'(lat), L + 1);
    check("cpu read data", crd[0], 32'hDEADBEEF);
    // debug write then CPU read of the same word
    op(1'b1, 1'b1, 32'h20, 32'h2A, lat);
    check("dbg write owner", 32'(own), 32'h3);
    op(1'b0, 1'b0, 32'h20, 32'h0, lat);
    check("cpu read after dbg write", crd[0], 32'h2A);
    check("cpu read owner", 32'(own), 0);
    // both requesting continuously, from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    n0 = 0; n1 = 0; s0 = '0; s1 = '0;
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      if ((cack[0] || dack[0]) && n0 < 10) begin s0[n0] = dack[0]; n0++; end
      if ((cack[1] || dack[1]) && n1 < 10) begin s1[n1] = dack[1]; n1++; ta.push_back(k); end
    end
    tick();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    wait_idle();
    check("prio grant count", 32'(n0), 10);
    check("prio grant order", 32'(s0), 32'h210);
    check("rr grant order", 32'(s1), 32'h2AA);
    check("rr ack spacing 0-1", 32'(ta[1] - ta[0]), L + 2);
    check("rr ack spacing 2-3", 32'(ta[3] - ta[2]), L + 2);
    check("dbg read data", drd[0], 32'hDEADBEEF);
    // reset during the second access cycle of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1234;
    tick();
    tick();
    rst = 1'b1;
    cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid reset cpu_ack", 32'(cack), 0);
    check("mid reset mem_en", 32'(men), 0);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset mem_addr", maddr[0], 0);
    tick();
    op(1'b0, 1'b0, 32'h10, 32'h0, lat);
    check("post reset latency", 32'(lat), L + 1);
    check("post reset data", crd[0], 32'hDEADBEEF);
    // request fields change after the grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    tick();
    cpu_addr = 32'h14;
    @(negedge clk);
    check("held addr cycle 1", maddr[0], 32'h10);
    tick();
    @(negedge clk);
    check("held addr cycle 2", maddr[0], 32'h10);
    wait_ack(1'b0, lat);
    check("held addr ack", 32'(lat), 0);
    check("held addr data", crd[0], 32'hDEADBEEF);
    tick();
    cpu_req = 1'b0;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
